pipe_stage_chain: RTL and testbench
===================================

// Module: pipe_stage_chain
// PURPOSE
//  Parametrised chain of DEPTH pipeline registers with a valid bit per stage.
//  Generalises the fixed IF_ID/ID_EX/EX_MEM/MEM_WB registers of the 5-stage core.
//  Adds per-stage hold and flush, bubble collapse, output backpressure and an occupancy count.
//  Sits between issue logic (in_*) and a consumer (out_*).
//  Hazard logic drives hold/flush directly.
// PARAMETERS
//  WIDTH       32  payload bits per stage
//  DEPTH       4   number of stages, >=1; stage 0 = youngest, DEPTH-1 = oldest
//  FLUSH_ZERO  1   1: a flushed stage's payload is cleared to 0; 0: payload left unchanged
// PORTS
//  clock        in   1             rising-edge clock
//  reset        in   1             asynchronous, active-high reset
//  in_valid     in   1             upstream item present
//  in_data      in   WIDTH         upstream payload
//  in_ready     out  1             stage 0 can accept this cycle (combinational)
//  hold         in   DEPTH         hold[i]=1 freezes a valid item in stage i
//  flush        in   DEPTH         flush[i]=1 invalidates stage i at the next edge
//  out_valid    out  1             oldest stage presents an item
//  out_data     out  WIDTH         payload of stage DEPTH-1
//  out_ready    in   1             downstream accepts this cycle
//  stage_valid  out  DEPTH         registered valid bit of every stage
//  occupancy    out  $clog2(DEPTH+1)  registered count of valid stages
// BEHAVIOUR
//  Reset (async, immediate)
//   - all valid=0, all payload=0, occupancy=0.
//   - During reset: out_valid=0, in_ready=1.
//  Ready chain (combinational, from the oldest stage back)
//   - rdy[D-1] = !v[D-1] | (!hold[D-1] & out_ready)
//   - rdy[i]   = !v[i]   | (!hold[i]   & rdy[i+1])
//   - in_ready = rdy[0]
//   - An empty stage accepts even when its hold bit is set (bubble collapse).
//  Output
//   - out_valid = v[D-1] & !hold[D-1]; out_data = data[D-1].
//   - Transfer out occurs when out_valid & out_ready.
//  Moves
//   - Stage i leaves when v[i] & !hold[i] & rdy[i+1]; stage D-1 leaves on a transfer out.
//   - Source of stage 0 is in_valid & in_ready; source of stage i is the move from i-1.
//  Next-state per stage i
//   - flush[i] : v=0; data=0 if FLUSH_ZERO.
//   - else load: v=1, data=source payload.
//   - else leave: v=0, data kept.
//   - else: unchanged.
//  Flush rules
//   - flush[i] does not stop stage i's current item from moving on to i+1.
//   - flush[i] discards whatever stage i would hold after the edge.
//   - To kill an item currently in stage i while it advances, assert flush[i+1] as well.
//   - in_ready ignores flush; an item accepted into a flushed stage 0 counts as accepted and is dropped.
//   - Flush on an empty stage has no effect.
//  Single-cycle behaviour
//   - Latency through an empty, unheld chain is DEPTH cycles.
//   - Throughput is 1 item/cycle.
//   - A full chain with out_ready=1 shifts every stage in the same cycle (simultaneous load and leave).
//  Other rules
//   - occupancy = popcount of next valid bits, registered; always equals popcount(stage_valid).
//   - No payload is ever duplicated or reordered; items exit in input order.
//   - DEPTH=1 degenerates to a single register with hold/flush.
// TESTING
//  1 Reset, DEPTH=4, feed 0x11..0x44 back-to-back, out_ready=1:
//    out_data=0x11 on the 4th edge after the first accept, then 1/cycle; occupancy peaks at 4.
//  2 Full chain, out_ready=0 for 3 cycles:
//    in_ready=0, stage_valid=4'b1111, no data change.
//    Release: 4 items drain in order, then out_valid=0.
//  3 Items only in stages 0 and 2, hold[3]=1 with stage 3 empty, out_ready=0:
//    both items advance, ending in stages 1 and 3; hold on the empty stage is ignored.
//  4 flush[1]=1 while stage 0 holds 0xAB moving to stage 1:
//    stage 1 becomes invalid with payload 0 (FLUSH_ZERO=1); 0xAB never appears at out_data.
//  5 hold[2]=1 on a valid item for 2 cycles, continuous input:
//    stages 0-1 fill and freeze; stage 3 drains; in_ready=0 once stages 0-2 are all valid.
//  6 Assert reset mid-stream with 3 items in flight:
//    stage_valid=0, occupancy=0 and out_valid=0 immediately, before any clock edge.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: parametrised chain of DEPTH pipeline registers, each with
// its own valid bit. Supports per-stage hold and flush, bubble collapse (an
// empty stage always accepts, even while its hold bit is set), output
// backpressure and a registered occupancy count.
// Stage 0 is the youngest stage; stage DEPTH-1 is the oldest and drives out_*.
module pipe_stage_chain #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 4,
  parameter bit FLUSH_ZERO = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic [DEPTH-1:0]           hold,
  input  logic [DEPTH-1:0]           flush,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [DEPTH-1:0]           stage_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  // Per-stage state: valid bit and payload, indexed by stage number.
  logic [DEPTH-1:0] vld_p;
  logic [WIDTH-1:0] data_p [DEPTH];

  // Per-stage handshake terms and the valid vector after the coming edge.
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] leave;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] vld_nxt;
  logic [WIDTH-1:0] src [DEPTH];

  // Number of set bits in a stage-valid vector.
  function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + OCC_W'(v[i]);
    end
    return cnt;
  endfunction

  // Ready chain from the oldest stage back, moves, and next valid bits.
  // A running carry is used instead of reading rdy[i+1] so that no vector
  // feeds back on itself combinationally.
  always_comb begin
    logic carry;
    carry   = out_ready;
    rdy     = '0;
    leave   = '0;
    load    = '0;
    vld_nxt = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      // For the oldest stage carry is out_ready, so this is the transfer out.
      leave[i] = vld_p[i] & ~hold[i] & carry;
      // An empty stage is ready regardless of its hold bit.
      rdy[i]   = ~vld_p[i] | leave[i];
      carry    = rdy[i];
    end
    // in_ready ignores flush: an accepted item into a flushed stage 0 is dropped.
    load[0] = in_valid & rdy[0];
    for (int i = 1; i < DEPTH; i++) begin
      load[i] = leave[i-1];
    end
    // Flush wins over load, load wins over leave (a full shift keeps v=1).
    for (int i = 0; i < DEPTH; i++) begin
      if (flush[i]) begin
        vld_nxt[i] = 1'b0;
      end else if (load[i]) begin
        vld_nxt[i] = 1'b1;
      end else if (leave[i]) begin
        vld_nxt[i] = 1'b0;
      end else begin
        vld_nxt[i] = vld_p[i];
      end
    end
  end

  // Payload source for each stage: upstream input for stage 0, else the
  // previous stage's current payload.
  always_comb begin
    src[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src[i] = data_p[i-1];
    end
  end

  // Stage registers, occupancy register; async reset clears everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p     <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_p[i] <= '0;
      end
    end else begin
      vld_p     <= vld_nxt;
      occupancy <= popcount(vld_nxt);
      for (int i = 0; i < DEPTH; i++) begin
        if (flush[i]) begin
          // Flushing an empty, non-loading stage leaves its payload alone.
          if (FLUSH_ZERO && (vld_p[i] || load[i])) begin
            data_p[i] <= '0;
          end
        end else if (load[i]) begin
          data_p[i] <= src[i];
        end
      end
    end
  end

  // Output side: a held oldest stage presents nothing downstream.
  assign in_ready    = rdy[0];
  assign out_valid   = vld_p[DEPTH-1] & ~hold[DEPTH-1];
  assign out_data    = data_p[DEPTH-1];
  assign stage_valid = vld_p;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain (WIDTH=32, DEPTH=4, FLUSH_ZERO=1): directed
// vectors with literal expectations plus a slot-level reference model that
// is compared against the DUT on every falling clock edge outside reset.
module tb_pipe_stage_chain;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic [3:0]  hold = '0;
  logic [3:0]  flush = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic [3:0]  stage_valid;
  logic [2:0]  occupancy;

  int nvec  = 0;
  int nfail = 0;

  pipe_stage_chain #(.WIDTH(32), .DEPTH(4), .FLUSH_ZERO(1'b1)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .hold       (hold),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .stage_valid(stage_valid),
    .occupancy  (occupancy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: four slots, each empty or holding one item.
  logic [3:0]  mv;
  logic [31:0] md [4];
  logic [3:0]  m_rdy, m_lv, m_nv;
  logic [31:0] m_nd [4];
  logic [31:0] exit_q [$];

  // Which slots can hand their item on, scanning from the output end.
  always_comb begin
    logic space;
    space = out_ready;
    m_lv  = '0;
    m_rdy = '0;
    for (int i = 3; i >= 0; i--) begin
      m_lv[i]  = mv[i] & !hold[i] & space;
      m_rdy[i] = !mv[i] | m_lv[i];
      space    = m_rdy[i];
    end
  end

  // Slot contents after the edge.
  always_comb begin
    logic        arrives;
    logic [31:0] incoming;
    m_nv = mv;
    for (int i = 0; i < 4; i++) m_nd[i] = md[i];
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        arrives  = in_valid & m_rdy[0];
        incoming = in_data;
      end else begin
        arrives  = m_lv[i-1];
        incoming = md[i-1];
      end
      if (flush[i]) begin
        m_nv[i] = 1'b0;
        if (mv[i] | arrives) m_nd[i] = 32'h0;
      end else if (arrives) begin
        m_nv[i] = 1'b1;
        m_nd[i] = incoming;
      end else if (m_lv[i]) begin
        m_nv[i] = 1'b0;
      end
    end
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mv <= '0;
      for (int i = 0; i < 4; i++) md[i] <= '0;
    end else begin
      if (m_lv[3]) exit_q.push_back(md[3]);
      mv <= m_nv;
      for (int i = 0; i < 4; i++) md[i] <= m_nd[i];
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (!reset) begin
      chk("m_in_ready",    32'(in_ready),    32'(m_rdy[0]));
      chk("m_out_valid",   32'(out_valid),   32'(mv[3] & !hold[3]));
      chk("m_out_data",    out_data,         md[3]);
      chk("m_stage_valid", 32'(stage_valid), 32'(mv));
      chk("m_occupancy",   32'(occupancy),   32'($countones(mv)));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset state, checked before any clock edge.
    #1 reset = 1'b1;
    #1;
    chk("rst_in_ready",    32'(in_ready),    32'h1);
    chk("rst_out_valid",   32'(out_valid),   32'h0);
    chk("rst_stage_valid", 32'(stage_valid), 32'h0);
    chk("rst_occupancy",   32'(occupancy),   32'h0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;

    // 1: back-to-back 0x11..0x44, out_ready=1; first output after 4 edges.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 32'h11 * (k + 1);
      step();
    end
    in_valid = 1'b0;
    chk("t1_first_valid", 32'(out_valid), 32'h1);
    chk("t1_first_data",  out_data,       32'h11);
    chk("t1_occ_peak",    32'(occupancy), 32'h4);
    for (int k = 1; k < 4; k++) begin
      step();
      chk("t1_data", out_data, 32'h11 * (k + 1));
      chk("t1_occ",  32'(occupancy), 32'(4 - k));
    end
    step();
    chk("t1_empty", 32'(out_valid), 32'h0);
    chk("t1_log_n", 32'(exit_q.size()), 32'h4);
    if (exit_q.size() == 4) begin
      chk("t1_log0", exit_q[0], 32'h11);
      chk("t1_log3", exit_q[3], 32'h44);
    end
    exit_q.delete();

    // 2: fill, stall 3 cycles, then drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 32'hA1 + k;
      step();
    end
    in_data = 32'hA5;
    for (int k = 0; k < 3; k++) begin
      chk("t2_in_ready", 32'(in_ready),    32'h0);
      chk("t2_full",     32'(stage_valid), 32'hF);
      chk("t2_hold",     out_data,         32'hA1);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_drain", out_data, 32'hA1 + k);
      step();
    end
    chk("t2_empty", 32'(out_valid), 32'h0);
    exit_q.delete();

    // 3: items in stages 0 and 2, hold on empty stage 3, out_ready=0.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h31; step();
    in_valid = 1'b0;                   step();
    in_valid = 1'b1; in_data = 32'h32; step();
    in_valid = 1'b0;
    chk("t3_setup", 32'(stage_valid), 32'b0101);
    hold = 4'b1000;
    step();
    chk("t3_collapse", 32'(stage_valid), 32'b1010);
    chk("t3_held_out", 32'(out_valid),   32'h0);
    hold = 4'b0000;
    out_ready = 1'b1;
    #1;
    chk("t3_out", out_data, 32'h31);
    for (int k = 0; k < 4; k++) step();
    chk("t3_order", 32'(exit_q.size()), 32'h2);
    if (exit_q.size() == 2) chk("t3_second", exit_q[1], 32'h32);
    exit_q.delete();

    // 4: flush[1] kills 0xAB moving into stage 1; flush[3] zeroes payload.
    in_valid = 1'b1; in_data = 32'hAB; step();
    in_valid = 1'b0; flush = 4'b0010;  step();
    flush = 4'b0000;
    chk("t4_killed", 32'(stage_valid), 32'h0);
    for (int k = 0; k < 4; k++) step();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hCD; step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("t4_cd_out", out_data, 32'hCD);
    flush = 4'b1000; step();
    flush = 4'b0000;
    chk("t4_cd_gone", 32'(out_valid), 32'h0);
    chk("t4_zeroed",  out_data,       32'h0);
    chk("t4_no_exit", 32'(exit_q.size()), 32'h0);

    // 5: hold[2] on a valid item for 2 cycles with continuous input.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 32'h50 + k;
      step();
    end
    in_data = 32'h54;
    hold = 4'b0100;
    #1;
    chk("t5_block", 32'(in_ready), 32'h0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("t5_frozen", 32'(stage_valid), 32'b0111);
      chk("t5_in_rdy", 32'(in_ready),    32'h0);
    end
    hold = 4'b0000;
    in_valid = 1'b0;
    #1;
    chk("t5_release", 32'(in_ready), 32'h1);
    for (int k = 0; k < 4; k++) step();
    chk("t5_log_n", 32'(exit_q.size()), 32'h4);
    if (exit_q.size() == 4) chk("t5_log1", exit_q[1], 32'h51);
    exit_q.delete();

    // 6: async reset mid-stream with 3 items in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 32'h61 + k;
      step();
    end
    in_valid = 1'b0;
    step();
    chk("t6_before", 32'(occupancy), 32'h3);
    #2 reset = 1'b1;
    #1;
    chk("t6_stage_valid", 32'(stage_valid), 32'h0);
    chk("t6_occupancy",   32'(occupancy),   32'h0);
    chk("t6_out_valid",   32'(out_valid),   32'h0);
    chk("t6_in_ready",    32'(in_ready),    32'h1);
    chk("t6_out_data",    out_data,         32'h0);
    @(posedge clock);
    #1 reset = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
